btn_event_gen: RTL and testbench

- Turns a synchronised push-button level into debounced, edge-qualified game events: press, auto-repeat while held, and release.
- Sits between the per-button input synchroniser and the game-control logic, e.g. cannon move-left/right and fire.
- Events leave through a one-deep valid/ready slot, so the game FSM can consume them at its own pace.
- Also provides single-cycle strobes and a clean debounced level.

---
 rtl/btn_event_gen_pkg.sv | 16 +
 rtl/btn_event_gen_evt_slot.sv | 60 ++++++
 rtl/btn_event_gen.sv | 174 +++++++++++++++++
 tb/tb_btn_event_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_gen_pkg.sv
// Shared event codes and debounce/repeat FSM state encoding for btn_event_gen.
package btn_event_gen_pkg;

    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESS_CHK = 2'b01,
        HELD      = 2'b10,
        REL_CHK   = 2'b11
    } state_t;

endpackage

// File: rtl/btn_event_gen_evt_slot.sv
// One-deep valid/ready event register: press/release overwrite a stalled slot,
// repeats are discarded when the slot is stalled, and both cases raise a drop strobe.
module btn_event_gen_evt_slot
    import btn_event_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       post_valid,
    input  logic [1:0] post_code,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       evt_drop
);

    logic       valid_r, valid_s;
    logic [1:0] code_r, code_s;
    logic       drop_r, drop_s;

    // Next slot contents from the incoming post and the consumer handshake
    always_comb begin
        valid_s = valid_r;
        code_s  = code_r;
        drop_s  = 1'b0;
        if (post_valid) begin
            if (!valid_r || evt_ready) begin
                valid_s = 1'b1;
                code_s  = post_code;
            end else if (post_code == EVT_REPEAT) begin
                drop_s = 1'b1;
            end else begin
                code_s = post_code;
                drop_s = 1'b1;
            end
        end else if (valid_r && evt_ready) begin
            valid_s = 1'b0;
            code_s  = EVT_NONE;
        end else begin
            valid_s = valid_r;
        end
    end

    // Slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            code_r  <= EVT_NONE;
            drop_r  <= 1'b0;
        end else begin
            valid_r <= valid_s;
            code_r  <= code_s;
            drop_r  <= drop_s;
        end
    end

    assign evt_valid = valid_r;
    assign evt_code  = code_r;
    assign evt_drop  = drop_r;

endmodule

// File: rtl/btn_event_gen.sv
// Debounces a synchronised button level and emits press / auto-repeat / release
// events as one-cycle strobes and through a one-deep valid/ready slot.
module btn_event_gen
    import btn_event_gen_pkg::*;
#(
    parameter int STABLE_CNT    = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_sync,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       repeat_pulse,
    output logic       release_pulse,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_drop
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] REP_DLY   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_PER   = CNT_W'(REPEAT_PERIOD);
    localparam bit               REP_EN    = (REPEAT_DELAY != 0);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] stab_cnt_r, stab_cnt_s;
    logic [CNT_W-1:0] rep_cnt_r, rep_cnt_s;
    logic             level_s;
    logic             press_s, repeat_s, release_s;
    logic             post_valid_s;
    logic [1:0]       post_code_s;

    logic             btn_level_r;
    logic             press_pulse_r, repeat_pulse_r, release_pulse_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Debounce FSM: next state, counters and event detection
    always_comb begin
        state_s    = state_r;
        stab_cnt_s = stab_cnt_r;
        rep_cnt_s  = rep_cnt_r;
        level_s    = btn_level_r;
        press_s    = 1'b0;
        repeat_s   = 1'b0;
        release_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_sync) begin
                    state_s    = PRESS_CHK;
                    stab_cnt_s = CNT_ONE;
                end else begin
                    stab_cnt_s = CNT_ZERO;
                end
            end
            PRESS_CHK: begin
                if (!btn_sync) begin
                    state_s    = IDLE;
                    stab_cnt_s = CNT_ZERO;
                end else if (stab_cnt_r >= STAB_LAST) begin
                    state_s    = HELD;
                    stab_cnt_s = CNT_ZERO;
                    rep_cnt_s  = REP_DLY;
                    level_s    = 1'b1;
                    press_s    = 1'b1;
                end else begin
                    stab_cnt_s = sat_inc(stab_cnt_r);
                end
            end
            HELD: begin
                // The repeat timer runs on every HELD cycle, including the one that leaves for REL_CHK
                if (REP_EN && (rep_cnt_r == CNT_ZERO)) begin
                    repeat_s  = 1'b1;
                    rep_cnt_s = REP_PER;
                end else if (REP_EN) begin
                    rep_cnt_s = rep_cnt_r - CNT_ONE;
                end else begin
                    rep_cnt_s = rep_cnt_r;
                end
                if (!btn_sync) begin
                    state_s    = REL_CHK;
                    stab_cnt_s = CNT_ONE;
                end else begin
                    stab_cnt_s = CNT_ZERO;
                end
            end
            REL_CHK: begin
                if (btn_sync) begin
                    state_s    = HELD;
                    stab_cnt_s = CNT_ZERO;
                end else if (stab_cnt_r >= STAB_LAST) begin
                    state_s    = IDLE;
                    stab_cnt_s = CNT_ZERO;
                    rep_cnt_s  = CNT_ZERO;
                    level_s    = 1'b0;
                    release_s  = 1'b1;
                end else begin
                    stab_cnt_s = sat_inc(stab_cnt_r);
                end
            end
            default: begin
                state_s    = IDLE;
                stab_cnt_s = CNT_ZERO;
                rep_cnt_s  = CNT_ZERO;
                level_s    = 1'b0;
            end
        endcase
    end

    // Event post into the slot; the three sources are mutually exclusive
    always_comb begin
        post_valid_s = press_s | repeat_s | release_s;
        if (press_s) begin
            post_code_s = EVT_PRESS;
        end else if (release_s) begin
            post_code_s = EVT_RELEASE;
        end else if (repeat_s) begin
            post_code_s = EVT_REPEAT;
        end else begin
            post_code_s = EVT_NONE;
        end
    end

    // State, counters and registered strobes/level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            stab_cnt_r      <= CNT_ZERO;
            rep_cnt_r       <= CNT_ZERO;
            btn_level_r     <= 1'b0;
            press_pulse_r   <= 1'b0;
            repeat_pulse_r  <= 1'b0;
            release_pulse_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            stab_cnt_r      <= stab_cnt_s;
            rep_cnt_r       <= rep_cnt_s;
            btn_level_r     <= level_s;
            press_pulse_r   <= press_s;
            repeat_pulse_r  <= repeat_s;
            release_pulse_r <= release_s;
        end
    end

    btn_event_gen_evt_slot u_evt_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .post_valid (post_valid_s),
        .post_code  (post_code_s),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_drop   (evt_drop)
    );

    assign btn_level     = btn_level_r;
    assign press_pulse   = press_pulse_r;
    assign repeat_pulse  = repeat_pulse_r;
    assign release_pulse = release_pulse_r;

endmodule

// File: tb/tb_btn_event_gen.sv
// Self-checking bench for btn_event_gen: vector table, directed corner sequences,
// and randomized stimulus compared every cycle against a run-length/interval model.
module tb_btn_event_gen;

    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk;
    logic       rst_n;
    logic       btn_sync;
    logic       evt_ready;
    logic       btn_level, press_pulse, repeat_pulse, release_pulse;
    logic       evt_valid, evt_drop;
    logic [1:0] evt_code;

    int checks;
    int errors;

    // Reference model: run length of samples disagreeing with the debounced level,
    // and number of counted held cycles since the last press/repeat.
    logic       m_level;
    int         m_run;
    int         m_act;
    logic       m_first;
    logic       m_press, m_rep, m_rel, m_valid, m_drop;
    logic [1:0] m_code;

    typedef struct {
        logic       btn;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[16];

    int   rep_ticks[$];
    int   exp_rep[6];
    int   drop_cnt;
    int   len;
    logic cur;

    btn_event_gen #(
        .STABLE_CNT    (SC),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .CNT_W         (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_sync      (btn_sync),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .repeat_pulse  (repeat_pulse),
        .release_pulse (release_pulse),
        .evt_valid     (evt_valid),
        .evt_code      (evt_code),
        .evt_ready     (evt_ready),
        .evt_drop      (evt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] dut_vec();
        return {btn_level, press_pulse, repeat_pulse, release_pulse, evt_valid, evt_code, evt_drop};
    endfunction

    function automatic logic [7:0] mk(input logic lv, input logic p, input logic rp,
                                      input logic rl, input logic v, input logic [1:0] c,
                                      input logic d);
        return {lv, p, rp, rl, v, c, d};
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_level = 1'b0; m_run = 0; m_act = 0; m_first = 1'b0;
        m_press = 1'b0; m_rep = 1'b0; m_rel = 1'b0;
        m_valid = 1'b0; m_code = 2'b00; m_drop = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic r);
        logic       post;
        logic [1:0] pc;
        m_press = 1'b0; m_rep = 1'b0; m_rel = 1'b0; post = 1'b0; pc = 2'b00;
        if (m_level && m_run == 0) begin
            m_act++;
            if (RD != 0 && m_act == (m_first ? RD + 1 : RP + 1)) begin
                m_rep = 1'b1; m_act = 0; m_first = 1'b0; post = 1'b1; pc = 2'b10;
            end
        end
        if (b != m_level) begin
            m_run++;
            if (m_run == SC) begin
                m_level = b;
                m_run   = 0;
                post    = 1'b1;
                if (b) begin
                    m_press = 1'b1; m_act = 0; m_first = 1'b1; pc = 2'b01;
                end else begin
                    m_rel = 1'b1; pc = 2'b11;
                end
            end
        end else begin
            m_run = 0;
        end
        m_drop = 1'b0;
        if (post) begin
            if (!m_valid || r) begin
                m_valid = 1'b1; m_code = pc;
            end else if (pc == 2'b10) begin
                m_drop = 1'b1;
            end else begin
                m_code = pc; m_drop = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0; m_code = 2'b00;
        end
    endtask

    // Drive at the falling edge, advance one rising edge, compare at the next falling edge.
    task automatic tick(input logic b, input logic r);
        btn_sync  = b;
        evt_ready = r;
        @(posedge clk);
        model_step(b, r);
        @(negedge clk);
        cmp("model", dut_vec(), mk(m_level, m_press, m_rep, m_rel, m_valid, m_code, m_drop));
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; btn_sync = 1'b0; evt_ready = 1'b1;
        model_reset();

        tbl[0]  = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0)};
        tbl[1]  = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0)};
        tbl[2]  = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0)};
        tbl[3]  = '{1'b1, 1'b1, mk(1, 1, 0, 0, 1, 2'b01, 0)};
        tbl[4]  = '{1'b1, 1'b1, mk(1, 0, 0, 0, 0, 2'b00, 0)};
        tbl[5]  = '{1'b0, 1'b1, mk(1, 0, 0, 0, 0, 2'b00, 0)};
        tbl[6]  = '{1'b0, 1'b1, mk(1, 0, 0, 0, 0, 2'b00, 0)};
        tbl[7]  = '{1'b0, 1'b1, mk(1, 0, 0, 0, 0, 2'b00, 0)};
        tbl[8]  = '{1'b0, 1'b1, mk(0, 0, 0, 1, 1, 2'b11, 0)};
        tbl[9]  = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0)};
        tbl[10] = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0)};
        tbl[11] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0)};
        tbl[12] = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0)};
        tbl[13] = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0)};
        tbl[14] = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0)};
        tbl[15] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0)};

        exp_rep[0] = 15; exp_rep[1] = 19; exp_rep[2] = 23;
        exp_rep[3] = 27; exp_rep[4] = 31; exp_rep[5] = 37;

        // Reset state
        repeat (2) @(negedge clk);
        cmp("reset_outputs", dut_vec(), 8'h00);
        rst_n = 1'b1;

        // Clean press / release / short bursts from the vector table
        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].btn, tbl[i].rdy);
            cmp($sformatf("table_row%0d", i), dut_vec(), tbl[i].exp);
        end

        // Bounce rejection: 1,1,1,0 repeating never reaches four highs
        for (int i = 0; i < 24; i++) begin
            tick((i % 4) != 3, 1'b1);
            cmp("bounce_quiet", dut_vec(), 8'h00);
        end
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        // Auto-repeat, a 2-cycle glitch that shifts the next repeat, then release
        rep_ticks.delete();
        for (int k = 1; k <= 41; k++) begin
            tick(!((k == 33) || (k == 34) || (k >= 38)), 1'b1);
            if (repeat_pulse) rep_ticks.push_back(k);
            if (k == 4) cmp("press_at_4", {press_pulse, btn_level, evt_valid, evt_code}, 5'b11101);
            if (k == 15) cmp("repeat_code", {evt_valid, evt_code}, 3'b110);
            if (k == 41) cmp("release_at_41", {release_pulse, btn_level, evt_valid, evt_code}, 5'b10111);
        end
        cmp_int("repeat_count", rep_ticks.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rep_ticks.size()) cmp_int($sformatf("repeat_tick%0d", i), rep_ticks[i], exp_rep[i]);
            else cmp_int($sformatf("repeat_tick%0d", i), -1, exp_rep[i]);
        end
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        // Back-pressure: slot holds press, repeats dropped, release overwrites
        drop_cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            tick(k <= 20, 1'b0);
            if (evt_drop) drop_cnt++;
            if (k == 20) begin
                cmp("bp_hold_press", {evt_valid, evt_code}, 3'b101);
                cmp_int("bp_drops_before_release", drop_cnt, 2);
            end
        end
        cmp("bp_release_overwrite", {evt_valid, evt_code, evt_drop}, 4'b1111);
        cmp_int("bp_drops_total", drop_cnt, 3);
        tick(1'b0, 1'b1);
        cmp("bp_drain", {evt_valid, evt_code}, 3'b000);

        // Randomized runs of random length with random back-pressure
        cur = 1'b0;
        for (int i = 0; i < 160; i++) begin
            cur = ~cur;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) tick(cur, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset in the middle of a hold
        for (int k = 0; k < 6; k++) tick(1'b0, 1'b1);
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b1);
        cmp("pre_reset_held", {btn_level}, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_reset_clear", dut_vec(), 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1'b1, 1'b1);
            if (k == 3) cmp("post_reset_no_early_press", {press_pulse, release_pulse}, 2'b00);
            if (k == 4) cmp("post_reset_press_at_4", {press_pulse, release_pulse, evt_code}, 4'b1001);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
